mips_program_loader: RTL and testbench
======================================

Name: mips_program_loader

Overview:
Upstream stage of the multicycle MIPS core. It receives a program image as a byte stream, packs the bytes into 32-bit words, and writes them into the 128-word instruction/data memory through that memory's CS/WE/ADDR/Mem_Bus port. The CPU is held in reset until the image is fully written. This replaces testbench-only memory initialisation and enables reprogramming on the board without re-synthesis.

Parameters:
ADDR_W, 7, memory word-address width
MEM_WORDS, 128, memory depth in words; the highest writable address is MEM_WORDS-1
RELEASE_DLY, 4, number of CLK cycles between the final write and cpu_rst deasserting

Ports:
CLK  in  1  system clock; all state changes on posedge
RST  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that begins a load; honoured only in IDLE or DONE
byte_in  in  8  image byte
byte_valid  in  1  byte_in is valid this cycle
byte_last  in  1  marks the final image byte; qualified by byte_valid
byte_ready  out  1  loader can accept a byte
bus_own  out  1  select for the top-level mux: 1 = loader drives memory CS/WE/ADDR
CS  out  1  memory chip select
WE  out  1  memory write enable
ADDR  out  ADDR_W  memory word address
Mem_Bus  inout  32  memory data bus; driven only while WE=1, otherwise high-Z
cpu_rst  out  1  active-high reset to the MIPS core
done  out  1  image loaded and CPU released
error  out  1  sticky fault flag
word_count  out  8  number of words written in the current load

Behaviour:
- Reset (RST=0, asynchronous) forces every output to a fixed value: state=IDLE, byte_ready=0, bus_own=0, CS=0, WE=0, ADDR=0, Mem_Bus=Z, cpu_rst=1, done=0, error=0, word_count=0.
- States: IDLE, COLLECT, WRITE, CHECK (only when LOADER_CHECKSUM_EN is defined), RELEASE, DONE.
- IDLE: cpu_rst=1. On start, go to COLLECT: clear word_count, ADDR, byte lane, and error; set bus_own=1.
- COLLECT: byte_ready=1. A byte transfers on a posedge where byte_valid=1 and byte_ready=1. Packing is big-endian: the first byte goes to [31:24], the fourth to [7:0]. After the fourth byte, or after a byte with byte_last=1, go to WRITE.
- Partial final word: unfilled low bytes are zero. Example: 2 bytes AA BB with last set -> word 0xAABB0000.
- WRITE: lasts exactly 1 cycle; byte_ready=0.
  - CS=1, WE=1, ADDR, and the word are registered and held for the full cycle so the memory captures them on the intervening negedge.
  - On the next posedge: word_count+1, ADDR+1.
  - If the word was last, go to RELEASE (or CHECK if enabled); otherwise go to COLLECT.
- Throughput: at most one word per 5 cycles (4 byte cycles + 1 write cycle). With no stalls, latency from the 4th byte accepted to the memory write is 1 cycle.
- Overflow: if a 5th byte would need to go to address MEM_WORDS, that byte is not accepted. Set error=1 and go to DONE with cpu_rst held at 1. ADDR never wraps to 0.
- RELEASE: bus_own=0, CS=0, WE=0. Count RELEASE_DLY cycles, then cpu_rst=0 and go to DONE.
- DONE: done=1 only when error=0. cpu_rst stays at its current value. A start pulse here begins a new load: cpu_rst=1, done=0, go to COLLECT.
- start during COLLECT, WRITE, CHECK, or RELEASE is ignored.
- byte_valid in any state other than COLLECT or CHECK is ignored; no byte transfers.
- Zero-length image (start then immediately RELEASE) is not possible; at least one byte is required.
- error is sticky until the next start or reset.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - An 8-bit running sum (mod 256) covers all image bytes.
  - After the last word's WRITE, enter CHECK with byte_ready=1 and accept exactly one checksum byte.
  - Match -> RELEASE.
  - Mismatch -> error=1, go to DONE, cpu_rst stays 1.
- Undefined: no CHECK state and no sum logic; after the final write, go directly to RELEASE.

Test Plan:
- Reset mid-load: assert RST=0 after 2 words -> all outputs return to their reset values immediately; the next start loads from ADDR 0.
- Full-word load: start, then 8 bytes 20 01 00 05 / 20 02 00 0C with last on the final byte -> RAM[0]=0x20010005, RAM[1]=0x2002000C; word_count=2; cpu_rst falls RELEASE_DLY cycles after the second write; done=1.
- Partial word: start, then 5 bytes 11 22 33 44 55 with last on the final byte -> RAM[0]=0x11223344, RAM[1]=0x55000000, word_count=2.
- Stalled stream: byte_valid toggles 1/0 every cycle over 4 bytes DE AD BE EF -> RAM[0]=0xDEADBEEF; exactly one WE pulse; byte_ready=0 during WRITE.
- Overflow: 513 bytes with no last -> 128 words written, 513th byte refused, error=1, cpu_rst=1, done=0, ADDR=127 at the final write.
- Checksum (macro defined): bytes 01 02 03 04 with last, then 0x0A -> done=1. Same bytes followed by 0x0B -> error=1, cpu_rst=1.

Source files
------------

// File: rtl/mips_program_loader.sv
// Byte-stream program loader: packs bytes big-endian into words, writes the MIPS memory, then releases the CPU.
// Optional LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte check.
module mips_program_loader #(
    parameter int ADDR_W      = 7,
    parameter int MEM_WORDS   = 128,
    parameter int RELEASE_DLY = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              bus_own,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [31:0]       Mem_Bus,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

    localparam int DW = (RELEASE_DLY > 1) ? $clog2(RELEASE_DLY) : 1;
    localparam logic [DW-1:0]     DLY_LAST  = DW'(RELEASE_DLY - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WRITE, S_CHECK, S_RELEASE, S_DONE
    } state_t;

    state_t        state;
    logic [1:0]    lane;
    logic [31:0]   wdata;
    logic          last_word;
    logic          full;
    logic [DW-1:0] dly_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum;
`endif

    assign Mem_Bus = WE ? wdata : 32'bz;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            lane       <= 2'd0;
            wdata      <= 32'd0;
            last_word  <= 1'b0;
            full       <= 1'b0;
            dly_cnt    <= '0;
            byte_ready <= 1'b0;
            bus_own    <= 1'b0;
            CS         <= 1'b0;
            WE         <= 1'b0;
            ADDR       <= '0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            sum        <= 8'd0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_COLLECT;
                        lane       <= 2'd0;
                        full       <= 1'b0;
                        ADDR       <= '0;
                        word_count <= 8'd0;
                        error      <= 1'b0;
                        bus_own    <= 1'b1;
                        byte_ready <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        sum        <= 8'd0;
`endif
                    end
                end
                S_COLLECT: begin
                    // Memory is full: the next offered byte has nowhere to go.
                    if (full) begin
                        if (byte_valid) begin
                            error      <= 1'b1;
                            bus_own    <= 1'b0;
                            byte_ready <= 1'b0;
                            state      <= S_DONE;
                        end
                    end else if (byte_valid && byte_ready) begin
                        unique case (lane)
                            2'd0: wdata         <= {byte_in, 24'd0};
                            2'd1: wdata[23:16]  <= byte_in;
                            2'd2: wdata[15:8]   <= byte_in;
                            2'd3: wdata[7:0]    <= byte_in;
                        endcase
                        lane      <= lane + 2'd1;
                        last_word <= byte_last;
`ifdef LOADER_CHECKSUM_EN
                        sum       <= sum + byte_in;
`endif
                        if (lane == 2'd3 || byte_last) begin
                            state      <= S_WRITE;
                            lane       <= 2'd0;
                            CS         <= 1'b1;
                            WE         <= 1'b1;
                            byte_ready <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    CS         <= 1'b0;
                    WE         <= 1'b0;
                    word_count <= word_count + 8'd1;
                    if (ADDR == LAST_ADDR)
                        full <= 1'b1;
                    else
                        ADDR <= ADDR + ADDR_W'(1);
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= S_CHECK;
                        byte_ready <= 1'b1;
`else
                        state      <= S_RELEASE;
                        bus_own    <= 1'b0;
                        dly_cnt    <= '0;
`endif
                    end else begin
                        state      <= S_COLLECT;
                        byte_ready <= (ADDR != LAST_ADDR);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (byte_valid) begin
                        byte_ready <= 1'b0;
                        bus_own    <= 1'b0;
                        if (byte_in == sum) begin
                            state   <= S_RELEASE;
                            dly_cnt <= '0;
                        end else begin
                            error <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
`endif
                S_RELEASE: begin
                    if (dly_cnt == DLY_LAST) begin
                        cpu_rst <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        dly_cnt <= dly_cnt + DW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed self-checking bench for mips_program_loader with a behavioural RAM on the memory port.
// Checksum scenario is built only when LOADER_CHECKSUM_EN is defined.
module tb_mips_program_loader;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        bus_own;
    logic        CS;
    logic        WE;
    logic [6:0]  ADDR;
    wire  [31:0] mem_bus;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [7:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [0:127];
    int          we_pulses;
    logic [6:0]  last_we_addr;

    mips_program_loader #(
        .ADDR_W(7), .MEM_WORDS(128), .RELEASE_DLY(4)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(byte_ready), .bus_own(bus_own),
        .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(mem_bus),
        .cpu_rst(cpu_rst), .done(done), .error(error),
        .word_count(word_count)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory captures on the negedge inside the write cycle.
    always @(negedge CLK) begin
        if (CS && WE) begin
            ram[ADDR]    = mem_bus;
            last_we_addr = ADDR;
            we_pulses    = we_pulses + 1;
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        we_pulses = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int  t;
        logic acc;
        t   = 0;
        acc = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        while (!acc && t < 20) begin
            acc = byte_ready;
            tick();
            t++;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_byte: byte %h not accepted within %0d cycles", b, t);
        end
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while (!done && !error && t < 100) begin
            tick();
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL %s: no done/error after %0d cycles", name, t);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [19:0] got;
        got = {byte_ready, bus_own, CS, WE, ADDR, cpu_rst, done, error, word_count};
        checks++;
        if (got !== {4'b0000, 7'd0, 3'b100, 8'd0}) begin
            errors++;
            $display("FAIL %s: outputs %h, expected %h", name, got,
                     {4'b0000, 7'd0, 3'b100, 8'd0});
        end
    endtask

    task automatic test_reset();
        RST        = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        clear_ram();
        #12;
        check_reset_outputs("reset_state");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        tick();
        byte_in    = 8'h5A;
        byte_valid = 1'b1;
        repeat (3) tick();
        byte_valid = 1'b0;
        checks++;
        if ({byte_ready, bus_own, word_count, WE} !== 11'd0) begin
            errors++;
            $display("FAIL idle_ignore: ready=%b own=%b wc=%0d we=%b, expected 0 0 0 0",
                     byte_ready, bus_own, word_count, WE);
        end
        checks++;
        if (we_pulses !== 0) begin
            errors++;
            $display("FAIL idle_ignore_we: %0d writes, expected 0", we_pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] img [8];
        img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        clear_ram();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
        tick();
        checks++;
        if (word_count !== 8'd2 || ADDR !== 7'd2) begin
            errors++;
            $display("FAIL mid_pre: wc=%0d addr=%0d, expected 2 2", word_count, ADDR);
        end
        RST = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        tick();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        wait_end("mid_reload");
        checks++;
        if (ram[0] !== 32'h01020304 || last_we_addr !== 7'd0 || word_count !== 8'd1) begin
            errors++;
            $display("FAIL mid_reload_data: ram0=%h addr=%0d wc=%0d, expected 01020304 0 1",
                     ram[0], last_we_addr, word_count);
        end
    endtask

    task automatic test_full_word();
        logic [7:0] img [8];
        int n;
        img = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0C};
        clear_ram();
        pulse_start();
        checks++;
        if (bus_own !== 1'b1 || byte_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL full_start: own=%b ready=%b rst=%b done=%b, expected 1 1 1 0",
                     bus_own, byte_ready, cpu_rst, done);
        end
        for (int i = 0; i < 4; i++) send_byte(img[i], 1'b0);
        checks++;
        if (WE !== 1'b1 || CS !== 1'b1 || ADDR !== 7'd0 || mem_bus !== 32'h20010005) begin
            errors++;
            $display("FAIL full_latency: we=%b cs=%b addr=%0d bus=%h, expected 1 1 0 20010005",
                     WE, CS, ADDR, mem_bus);
        end
        for (int i = 4; i < 8; i++) send_byte(img[i], i == 7);
        checks++;
        if (WE !== 1'b1 || byte_ready !== 1'b0 || ADDR !== 7'd1) begin
            errors++;
            $display("FAIL full_write2: we=%b ready=%b addr=%0d, expected 1 0 1",
                     WE, byte_ready, ADDR);
        end
        n = 0;
        while (cpu_rst && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL full_release_dly: cpu_rst fell %0d cycles after write, expected 5", n);
        end
        checks++;
        if (ram[0] !== 32'h20010005 || ram[1] !== 32'h2002000C) begin
            errors++;
            $display("FAIL full_ram: %h %h, expected 20010005 2002000c", ram[0], ram[1]);
        end
        checks++;
        if (word_count !== 8'd2 || done !== 1'b1 || error !== 1'b0 || bus_own !== 1'b0) begin
            errors++;
            $display("FAIL full_status: wc=%0d done=%b err=%b own=%b, expected 2 1 0 0",
                     word_count, done, error, bus_own);
        end
        checks++;
        if (we_pulses !== 2) begin
            errors++;
            $display("FAIL full_we_count: %0d, expected 2", we_pulses);
        end
    endtask

    task automatic test_partial();
        logic [7:0] img [5];
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        clear_ram();
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL restart_from_done: done=%b rst=%b, expected 0 1", done, cpu_rst);
        end
        for (int i = 0; i < 5; i++) send_byte(img[i], i == 4);
        wait_end("partial");
        checks++;
        if (ram[0] !== 32'h11223344 || ram[1] !== 32'h55000000) begin
            errors++;
            $display("FAIL partial_ram: %h %h, expected 11223344 55000000", ram[0], ram[1]);
        end
        checks++;
        if (word_count !== 8'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL partial_status: wc=%0d done=%b, expected 2 1", word_count, done);
        end
    endtask

    task automatic test_stall();
        logic [7:0] img [4];
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_ram();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(img[i], i == 3);
            if (i < 3) tick();
        end
        checks++;
        if (WE !== 1'b1 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_write: we=%b ready=%b, expected 1 0", WE, byte_ready);
        end
        wait_end("stall");
        checks++;
        if (ram[0] !== 32'hDEADBEEF || we_pulses !== 1) begin
            errors++;
            $display("FAIL stall_ram: %h pulses=%0d, expected deadbeef 1", ram[0], we_pulses);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] v;
        logic taken;
        clear_ram();
        pulse_start();
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            send_byte(v[7:0], 1'b0);
        end
        checks++;
        if (WE !== 1'b1 || ADDR !== 7'd127) begin
            errors++;
            $display("FAIL ovf_last_write: we=%b addr=%0d, expected 1 127", WE, ADDR);
        end
        taken      = 1'b0;
        byte_in    = 8'hFF;
        byte_valid = 1'b1;
        for (int t = 0; t < 10 && !error; t++) begin
            if (byte_ready && !WE) taken = 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || taken !== 1'b0) begin
            errors++;
            $display("FAIL ovf_status: err=%b rst=%b done=%b taken=%b, expected 1 1 0 0",
                     error, cpu_rst, done, taken);
        end
        checks++;
        if (we_pulses !== 128 || word_count !== 8'd128 || ADDR !== 7'd127) begin
            errors++;
            $display("FAIL ovf_count: pulses=%0d wc=%0d addr=%0d, expected 128 128 127",
                     we_pulses, word_count, ADDR);
        end
        checks++;
        if (ram[0] !== 32'h00010203 || ram[127] !== 32'hFCFDFEFF) begin
            errors++;
            $display("FAIL ovf_ram: %h %h, expected 00010203 fcfdfeff", ram[0], ram[127]);
        end
        repeat (3) tick();
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: err=%b rst=%b, expected 1 1", error, cpu_rst);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_ram();
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        send_byte(8'h0A, 1'b0);
        wait_end("csum_good");
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_rst !== 1'b0) begin
            errors++;
            $display("FAIL csum_good: done=%b err=%b rst=%b, expected 1 0 0",
                     done, error, cpu_rst);
        end
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b1);
        send_byte(8'h0B, 1'b0);
        wait_end("csum_bad");
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: err=%b rst=%b done=%b, expected 1 1 0",
                     error, cpu_rst, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid();
        test_full_word();
        test_partial();
        test_stall();
        test_overflow();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
